// File: rtl/pdu_recv_tracker.sv
// Per-source received-PDU bitmaps for the current macrocycle, plus a show-ahead
// event FIFO of accepted frame descriptors for the upper protocol logic.
module pdu_recv_tracker #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_macro_start_trig,
  input  logic        i_recv_data_legal,
  input  logic        i_rd_en,
  input  logic [5:0]  i_src_mac_low,
  input  logic [7:0]  i_frt_type,
  input  logic [3:0]  i_recv_status,
  input  logic        i_frame_err,
  output logic [63:0] o_frt_sent,
  output logic [63:0] o_mcc_sent,
  output logic [63:0] o_syncreq_sent,
  output logic [63:0] o_syncrsp_sent,
  output logic        o_evt_valid,
  output logic [19:0] o_evt_data,
  input  logic        i_evt_rd,
  output logic        o_evt_overflow,
  output logic [7:0]  o_recv_cnt,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_END = 2'd1,
    ST_COMMIT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        legal_d, rd_en_d;
  logic        legal_rise, rd_fall;
  logic [5:0]  cap_src;
  logic [7:0]  cap_type;
  logic [3:0]  cap_status;
  logic [1:0]  cap_cls;
  logic        cap_drop;
  logic [1:0]  in_cls;
  logic        in_cls_ok;
  logic [3:0][63:0] bm;
  logic        accept;

  logic [19:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          do_pop, do_push, push_drop;

  assign legal_rise = i_recv_data_legal & ~legal_d;
  assign rd_fall    = rd_en_d & ~i_rd_en;

  always_comb begin
    in_cls    = 2'd0;
    in_cls_ok = 1'b1;
    case (i_frt_type)
      8'h10:   in_cls = 2'd0;
      8'h20:   in_cls = 2'd2;
      8'h21:   in_cls = 2'd3;
      default: begin
        if (i_frt_type[7:4] == 4'h9) in_cls = 2'd1;
        else                         in_cls_ok = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      legal_d <= 1'b0;
      rd_en_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      legal_d <= i_recv_data_legal;
      rd_en_d <= i_rd_en;
    end
  end

  // A falling rd_en wins over a simultaneous legal drop: the frame tail is complete.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (legal_rise) state_nxt = ST_WAIT_END;
      ST_WAIT_END: begin
        if (rd_fall)                 state_nxt = ST_COMMIT;
        else if (!i_recv_data_legal) state_nxt = ST_IDLE;
      end
      ST_COMMIT:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap_src    <= '0;
      cap_type   <= '0;
      cap_status <= '0;
      cap_cls    <= '0;
      cap_drop   <= 1'b0;
    end else if (state == ST_IDLE && legal_rise) begin
      cap_src    <= i_src_mac_low;
      cap_type   <= i_frt_type;
      cap_status <= i_recv_status;
      cap_cls    <= in_cls;
      cap_drop   <= ~in_cls_ok;
    end
  end

  // A coincident macrocycle trigger clears the bitmaps first, so the duplicate
  // check sees an empty bitmap.
  assign accept = (state == ST_COMMIT) & ~i_frame_err & ~cap_drop &
                  ~(bm[cap_cls][cap_src] & ~i_macro_start_trig);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bm             <= '0;
      o_recv_cnt     <= '0;
      o_evt_overflow <= 1'b0;
    end else begin
      if (i_macro_start_trig) begin
        bm             <= '0;
        o_recv_cnt     <= accept ? 8'd1 : 8'd0;
        o_evt_overflow <= 1'b0;
      end else if (accept && o_recv_cnt != 8'hFF) begin
        o_recv_cnt <= o_recv_cnt + 8'd1;
      end
      if (accept)    bm[cap_cls][cap_src] <= 1'b1;
      if (push_drop) o_evt_overflow       <= 1'b1;
    end
  end

  assign o_frt_sent     = bm[0];
  assign o_mcc_sent     = bm[1];
  assign o_syncreq_sent = bm[2];
  assign o_syncrsp_sent = bm[3];

  // Consumer handshake: o_evt_valid/o_evt_data present the head; i_evt_rd pops
  // it at the clock edge when valid, and is ignored when the FIFO is empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == PW'(FIFO_DEPTH));
  assign do_pop     = i_evt_rd & ~fifo_empty;
  assign do_push    = accept & (~fifo_full | do_pop);
  assign push_drop  = accept & fifo_full & ~do_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= {cap_cls, cap_status, cap_src, cap_type};
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign o_evt_valid = ~fifo_empty;
  assign o_evt_data  = fifo_empty ? 20'd0 : mem[rd_ptr[AW-1:0]];

endmodule
